// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Latency: 34 edges from the accepting edge to done for normal ops, 2 edges for
//   divide-by-zero and signed-overflow divides.
// Backpressure: none; start is sampled only while idle, and the pipeline stalls on busy.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, funct3, op_a, op_b, rd_in   request, RV32M op, rs1/rs2 values, dest index
//   busy, done                op in flight, one-cycle completion pulse
//   result, rd_out, reg_write register-file write port (result/rd_out hold until next op)
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            reg_write
);

   localparam int CW = $clog2(ITER);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   state_t state, state_nxt;

   logic [2:0]       op;
   logic [4:0]       rd_lat;
   logic [CW-1:0]    count;
   logic [XLEN-1:0]  b_mag;        // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc;         // mul: {partial product, multiplier}; div: low half = dividend/quotient
   logic [XLEN-1:0]  rem;          // divide partial remainder (always < divisor)
   logic             neg_res;      // product/quotient needs negation
   logic             neg_rem;      // remainder takes dividend sign
   logic             special;
   logic [XLEN-1:0]  special_val;

   // ---------------- request decode (used only on the accepting edge) ----------------
   logic            is_div_in, a_signed_in, b_signed_in, a_sign, b_sign;
   logic            div_zero_in, ovf_in, special_in;
   logic [XLEN-1:0] a_abs, b_abs, special_val_in;

   always_comb begin
      is_div_in   = funct3[2];
      // unsigned variants: MULHU (011), DIVU (101), REMU (111); MULHSU (010) has unsigned rs2
      a_signed_in = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
      b_signed_in = a_signed_in && (funct3 != 3'b010);
      a_sign      = a_signed_in && op_a[XLEN-1];
      b_sign      = b_signed_in && op_b[XLEN-1];
      a_abs       = a_sign ? -op_a : op_a;
      b_abs       = b_sign ? -op_b : op_b;
      div_zero_in = is_div_in && (op_b == '0);
      ovf_in      = is_div_in && !funct3[0] && (op_a == SMIN) && (op_b == '1);
      special_in  = div_zero_in || ovf_in;
      special_val_in = '0;
      if (div_zero_in)
         special_val_in = funct3[1] ? op_a : '1;
      else if (ovf_in)
         special_val_in = funct3[1] ? '0 : SMIN;
   end

   // ---------------- one iteration of shift-add / restoring divide ----------------
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;    // 33-bit partial remainder after shifting in next dividend bit
   logic            div_ge;
   logic [XLEN-1:0] div_rem_nxt;

   always_comb begin
      mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
      div_shift   = {rem, acc[XLEN-1]};
      div_ge      = div_shift >= {1'b0, b_mag};
      div_rem_nxt = div_ge ? XLEN'(div_shift - {1'b0, b_mag}) : div_shift[XLEN-1:0];
   end

   // ---------------- sign fix-up and result select ----------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fin_val;

   always_comb begin
      prod_fix = neg_res ? -acc : acc;
      quot_fix = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix  = neg_rem ? -rem : rem;
      case (op)
         3'b000:                 fin_val = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_val = quot_fix;
         default:                fin_val = rem_fix;
      endcase
      if (special)
         fin_val = special_val;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = special_in ? FIN : CALC;
         CALC:    if (count == CW'(ITER-1)) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath and registered outputs ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         reg_write   <= 1'b0;
         result      <= '0;
         rd_out      <= '0;
         op          <= '0;
         rd_lat      <= '0;
         count       <= '0;
         b_mag       <= '0;
         acc         <= '0;
         rem         <= '0;
         neg_res     <= 1'b0;
         neg_rem     <= 1'b0;
         special     <= 1'b0;
         special_val <= '0;
      end else begin
         done      <= 1'b0;
         reg_write <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op          <= funct3;
                  rd_lat      <= rd_in;
                  busy        <= 1'b1;
                  count       <= '0;
                  special     <= special_in;
                  special_val <= special_val_in;
                  neg_res     <= a_sign ^ b_sign;
                  neg_rem     <= a_sign;
                  b_mag       <= b_abs;
                  acc         <= {{XLEN{1'b0}}, a_abs};
                  rem         <= '0;
               end
            end
            CALC: begin
               count <= count + 1'b1;
               if (op[2]) begin
                  acc[XLEN-1:0] <= {acc[XLEN-2:0], div_ge};
                  rem           <= div_rem_nxt;
               end else begin
                  acc <= {mul_sum, acc[XLEN-1:1]};
               end
            end
            FIN: begin
               result    <= fin_val;
               rd_out    <= rd_lat;
               reg_write <= (rd_lat != 5'd0);
               done      <= 1'b1;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, busy/done/reg_write
// behaviour, ignored starts, back-to-back issue and asynchronous mid-operation reset.
// Inputs change after the falling edge; outputs are sampled on the falling edge.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        busy, done, reg_write;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int tests = 0;
   int fails = 0;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out),
      .reg_write(reg_write)
   );

   // Issues one request and returns at the falling edge where done is first seen.
   // edges counts rising edges from the accepting one to the one that raised done.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int edges, output logic timeout);
      logic seen;
      funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      edges = 1;
      #1;
      start = 1'b0;
      op_a = $urandom; op_b = $urandom;   // operands are free to change after acceptance
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            @(posedge clk);
            edges++;
         end
      end
      timeout = !seen;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, done, reg_write, result, rd_out} !== 40'd0) begin
         fails++; $display("FAIL reset_in: got %h required 0", {busy, done, reg_write, result, rd_out});
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, done, reg_write, result, rd_out} !== 40'd0) begin
         fails++; $display("FAIL reset_out: got %h required 0", {busy, done, reg_write, result, rd_out});
      end
   endtask

   task automatic test_mul;
      int e; logic to;
      run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, e, to);
      tests++;
      if (to || e != 34) begin fails++; $display("FAIL mul_latency: got %0d (timeout %0b) required 34", e, to); end
      tests++;
      if (result !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_result: got %h required ffffffeb", result); end
      tests++;
      if (rd_out !== 5'd5 || reg_write !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL mul_wb: got rd %0d we %0b busy %0b required rd 5 we 1 busy 0", rd_out, reg_write, busy);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || reg_write !== 1'b0 || result !== 32'hFFFF_FFEB || rd_out !== 5'd5) begin
         fails++; $display("FAIL mul_pulse: got done %0b we %0b res %h rd %0d required 0 0 ffffffeb 5", done, reg_write, result, rd_out);
      end
   endtask

   task automatic test_mulh;
      int e; logic to;
      run_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, e, to);
      tests++;
      if (to || result !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mulhu: got %h required fffffffe", result); end
      run_op(F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, e, to);
      tests++;
      if (to || result !== 32'h0000_0000) begin fails++; $display("FAIL mulh: got %h required 00000000", result); end
      run_op(F_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, e, to);
      tests++;
      if (to || result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mulhsu: got %h required ffffffff", result); end
   endtask

   task automatic test_div;
      int e; logic to;
      run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, e, to);
      tests++;
      if (to || e != 34 || result !== 32'hFFFF_FFFD) begin
         fails++; $display("FAIL div: got %h after %0d edges required fffffffd after 34", result, e);
      end
      run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, e, to);
      tests++;
      if (to || result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem: got %h required ffffffff", result); end
      run_op(F_DIVU, 32'd100, 32'd7, 5'd6, e, to);
      tests++;
      if (to || result !== 32'd14) begin fails++; $display("FAIL divu: got %0d required 14", result); end
      run_op(F_REMU, 32'd100, 32'd7, 5'd6, e, to);
      tests++;
      if (to || result !== 32'd2) begin fails++; $display("FAIL remu: got %0d required 2", result); end
   endtask

   task automatic test_special;
      int e; logic to;
      run_op(F_DIVU, 32'd1234, 32'd0, 5'd7, e, to);
      tests++;
      if (to || e != 2 || result !== 32'hFFFF_FFFF) begin
         fails++; $display("FAIL divu_zero: got %h after %0d edges required ffffffff after 2", result, e);
      end
      run_op(F_REM, 32'd1234, 32'd0, 5'd8, e, to);
      tests++;
      if (to || e != 2 || result !== 32'd1234) begin
         fails++; $display("FAIL rem_zero: got %0d after %0d edges required 1234 after 2", result, e);
      end
      run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, e, to);
      tests++;
      if (to || e != 2 || result !== 32'h8000_0000) begin
         fails++; $display("FAIL div_ovf: got %h after %0d edges required 80000000 after 2", result, e);
      end
      run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, e, to);
      tests++;
      if (to || e != 2 || result !== 32'd0) begin
         fails++; $display("FAIL rem_ovf: got %h after %0d edges required 0 after 2", result, e);
      end
   endtask

   task automatic test_ignore_start;
      int e; logic seen;
      funct3 = F_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
      @(posedge clk);
      e = 1;
      #1;
      start = 1'b0;
      seen = 1'b0;
      for (int k = 1; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            if (k == 5 || k == 20) begin
               start = 1'b1; funct3 = F_MUL; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd1;
            end else begin
               start = 1'b0;
            end
            @(posedge clk);
            e++;
         end
      end
      start = 1'b0;
      tests++;
      if (!seen || e != 34 || result !== 32'd14 || rd_out !== 5'd9) begin
         fails++; $display("FAIL ignore_start: got %0d rd %0d after %0d edges required 14 rd 9 after 34", result, rd_out, e);
      end
   endtask

   task automatic test_rd_zero;
      int e; logic to;
      run_op(F_MUL, 32'd6, 32'd7, 5'd0, e, to);
      tests++;
      if (to || done !== 1'b1 || reg_write !== 1'b0 || result !== 32'd42) begin
         fails++; $display("FAIL rd_zero: got done %0b we %0b res %0d required 1 0 42", done, reg_write, result);
      end
   endtask

   task automatic test_back_to_back;
      int e; logic to;
      run_op(F_MULHU, 32'h0001_0000, 32'h0003_0000, 5'd10, e, to);
      tests++;
      if (to || result !== 32'd3) begin fails++; $display("FAIL b2b_first: got %h required 3", result); end
      // issued in the done cycle of the previous op
      run_op(F_DIV, 32'd50, 32'hFFFF_FFFB, 5'd11, e, to);
      tests++;
      if (to || e != 34 || result !== 32'hFFFF_FFF6 || rd_out !== 5'd11) begin
         fails++; $display("FAIL b2b_second: got %h rd %0d after %0d edges required fffffff6 rd 11 after 34", result, rd_out, e);
      end
   endtask

   task automatic test_reset_mid;
      int e; logic to; logic saw_done;
      funct3 = F_MUL; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd12; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || reg_write !== 1'b0 || rd_out !== 5'd0) begin
         fails++; $display("FAIL reset_mid: got busy %0b done %0b res %h required all 0", busy, done, result);
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      tests++;
      if (saw_done !== 1'b0) begin fails++; $display("FAIL reset_no_done: got activity %0b required 0", saw_done); end
      run_op(F_MUL, 32'd3, 32'd4, 5'd13, e, to);
      tests++;
      if (to || e != 34 || result !== 32'd12) begin
         fails++; $display("FAIL after_reset: got %0d after %0d edges required 12 after 34", result, e);
      end
   endtask

   initial begin
      test_reset;
      test_mul;
      test_mulh;
      test_div;
      test_special;
      test_ignore_start;
      test_rd_zero;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
